// File: rtl/instruction_fetch.sv
// Instruction fetch stage for the 16-bit SIMPLE pipeline.
// Owns the PC and fetches one word per instruction over a req/ack handshake.
// Stalls, branch redirects and HLT are handled with a small four-state FSM.
// DRAIN lets an outstanding request complete before the redirected or halted flow continues.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hC0E0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt_detect,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] program_counter_pre_if,
  output logic [15:0] instruction_register_if,
  output logic        fetch_valid,
  output logic        fetch_busy,
  output logic        halted
);

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_DRAIN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] stale_addr_q, stale_addr_d;
  logic [15:0] hold_instr_q, hold_instr_d;
  logic [15:0] hold_pcpre_q, hold_pcpre_d;
  logic        halt_pend_q, halt_pend_d;
  logic [15:0] pc_inc;

  // Address of the next sequential word; wraps from FFFF to 0000.
  assign pc_inc = pc_q + 16'd1;

  // State register: synchronous active-low reset restarts fetching at RESET_PC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      stale_addr_q <= 16'h0000;
      hold_instr_q <= NOP_INSTR;
      hold_pcpre_q <= 16'h0000;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pcpre_q <= hold_pcpre_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  // Next-state logic: branch beats halt, and halt beats the normal fetch and stall flow.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pcpre_d = hold_pcpre_q;
    halt_pend_d  = halt_pend_q;
    if (branch_taken && state_q != S_HALTED) begin
      // A redirect squashes any halt that was waiting behind the drain.
      pc_d        = branch_target;
      halt_pend_d = 1'b0;
      case (state_q)
        S_RUN: begin
          if (!imem_ack) begin
            stale_addr_d = pc_q;
            state_d      = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end
        S_HOLD:   state_d = S_RUN;
        S_DRAIN:  state_d = imem_ack ? S_RUN : S_DRAIN;
        S_HALTED: state_d = S_HALTED;
      endcase
    end else if (halt_detect && state_q != S_HALTED) begin
      case (state_q)
        S_RUN: begin
          if (!imem_ack) begin
            stale_addr_d = pc_q;
            halt_pend_d  = 1'b1;
            state_d      = S_DRAIN;
          end else begin
            state_d = S_HALTED;
          end
        end
        S_HOLD: state_d = S_HALTED;
        S_DRAIN: begin
          if (imem_ack) begin
            halt_pend_d = 1'b0;
            state_d     = S_HALTED;
          end else begin
            halt_pend_d = 1'b1;
          end
        end
        S_HALTED: state_d = S_HALTED;
      endcase
    end else begin
      case (state_q)
        S_RUN: begin
          if (imem_ack) begin
            if (pc_write) begin
              pc_d = pc_inc;
            end else begin
              hold_instr_d = imem_rdata;
              hold_pcpre_d = pc_inc;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (pc_write) begin
            pc_d    = pc_inc;
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          // The stale data is thrown away; pc already points at the new stream.
          if (imem_ack) begin
            halt_pend_d = 1'b0;
            state_d     = halt_pend_q ? S_HALTED : S_RUN;
          end
        end
        S_HALTED: state_d = S_HALTED;
      endcase
    end
  end

  // Output logic: forced idle while reset is low, otherwise decoded from the current state.
  always_comb begin
    imem_req                = 1'b0;
    imem_addr               = pc_q;
    instruction_register_if = NOP_INSTR;
    program_counter_pre_if  = 16'h0000;
    fetch_valid             = 1'b0;
    fetch_busy              = 1'b0;
    halted                  = 1'b0;
    if (reset) begin
      case (state_q)
        S_RUN: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            fetch_valid             = 1'b1;
            instruction_register_if = imem_rdata;
            program_counter_pre_if  = pc_inc;
          end else begin
            fetch_busy = 1'b1;
          end
        end
        S_HOLD: begin
          fetch_valid             = 1'b1;
          instruction_register_if = hold_instr_q;
          program_counter_pre_if  = hold_pcpre_q;
        end
        S_DRAIN: begin
          imem_req   = 1'b1;
          imem_addr  = stale_addr_q;
          fetch_busy = 1'b1;
        end
        S_HALTED: halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an expected-fetch queue.
// A wait-state memory model answers requests with rdata = addr ^ 16'h1000.
// Expected fetches are pushed when the consuming cycle is driven.
// A negedge monitor pops and compares every consumed fetch.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt_detect;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] program_counter_pre_if;
  logic [15:0] instruction_register_if;
  logic        fetch_valid;
  logic        fetch_busy;
  logic        halted;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcpre;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   waits    = 0;
  int   wait_cnt = 0;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock                   (clock),
    .reset                   (reset),
    .pc_write                (pc_write),
    .branch_taken            (branch_taken),
    .branch_target           (branch_target),
    .halt_detect             (halt_detect),
    .imem_req                (imem_req),
    .imem_addr               (imem_addr),
    .imem_ack                (imem_ack),
    .imem_rdata              (imem_rdata),
    .program_counter_pre_if  (program_counter_pre_if),
    .instruction_register_if (instruction_register_if),
    .fetch_valid             (fetch_valid),
    .fetch_busy              (fetch_busy),
    .halted                  (halted)
  );

  // Memory model: ack after 'waits' cycles of a held request, data = addr ^ 1000.
  assign imem_ack   = imem_req && (wait_cnt >= waits);
  assign imem_rdata = imem_addr ^ 16'h1000;

  always @(posedge clock) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_fetch(input logic [15:0] instr, input logic [15:0] pcpre);
    exp_t e;
    e.instr = instr;
    e.pcpre = pcpre;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: each consumed fetch must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset && fetch_valid && pc_write && !branch_taken && !halt_detect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fetch: got instr %h pc_pre %h, none required",
                 instruction_register_if, program_counter_pre_if);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fetch_instr", instruction_register_if, e.instr);
        chk("fetch_pcpre", program_counter_pre_if, e.pcpre);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pc_write = 1'b1; branch_taken = 1'b0; branch_target = 16'h0000;
    halt_detect = 1'b0; waits = 0;
    step();
    @(negedge clock);
    chk("rst_req",    {15'd0, imem_req}, 16'd0);
    chk("rst_instr",  instruction_register_if, 16'hC0E0);
    chk("rst_pcpre",  program_counter_pre_if, 16'h0000);
    chk("rst_valid",  {15'd0, fetch_valid}, 16'd0);
    chk("rst_busy",   {15'd0, fetch_busy}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);

    // Zero-wait memory: one instruction per cycle.
    step(); reset = 1'b1; expect_fetch(16'h1000, 16'h0001);
    @(negedge clock);
    chk("first_addr", imem_addr, 16'h0000);
    chk("first_req",  {15'd0, imem_req}, 16'd1);
    step(); expect_fetch(16'h1001, 16'h0002);
    step(); expect_fetch(16'h1002, 16'h0003);

    // Two-wait memory: valid on every third cycle.
    step(); waits = 2;
    @(negedge clock);
    chk("w2_valid0", {15'd0, fetch_valid}, 16'd0);
    chk("w2_busy0",  {15'd0, fetch_busy}, 16'd1);
    chk("w2_nop0",   instruction_register_if, 16'hC0E0);
    step();
    @(negedge clock);
    chk("w2_valid1", {15'd0, fetch_valid}, 16'd0);
    chk("w2_busy1",  {15'd0, fetch_busy}, 16'd1);
    step(); expect_fetch(16'h1003, 16'h0004);
    @(negedge clock);
    chk("w2_valid2", {15'd0, fetch_valid}, 16'd1);
    chk("w2_busy2",  {15'd0, fetch_busy}, 16'd0);

    // Stall on the ack at pc=4: hold the word for three cycles.
    step(); pc_write = 1'b0;
    @(negedge clock);
    chk("hold_fetch_addr", imem_addr, 16'h0004);
    step();
    step();
    @(negedge clock);
    chk("hold_ack_instr", instruction_register_if, 16'h1004);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock);
      chk("hold_req",   {15'd0, imem_req}, 16'd0);
      chk("hold_valid", {15'd0, fetch_valid}, 16'd1);
      chk("hold_instr", instruction_register_if, 16'h1004);
      chk("hold_pcpre", program_counter_pre_if, 16'h0005);
    end
    step(); pc_write = 1'b1; expect_fetch(16'h1004, 16'h0005);
    step();
    @(negedge clock);
    chk("after_hold_addr", imem_addr, 16'h0005);
    chk("after_hold_req",  {15'd0, imem_req}, 16'd1);

    // Branch while the fetch of 0005 waits: the request finishes, then 0040 is fetched.
    step(); branch_taken = 1'b1; branch_target = 16'h0040;
    @(negedge clock);
    chk("br_wait_addr", imem_addr, 16'h0005);
    step(); branch_taken = 1'b0;
    @(negedge clock);
    chk("drain_addr",  imem_addr, 16'h0005);
    chk("drain_req",   {15'd0, imem_req}, 16'd1);
    chk("drain_valid", {15'd0, fetch_valid}, 16'd0);
    chk("drain_busy",  {15'd0, fetch_busy}, 16'd1);
    step();
    @(negedge clock);
    chk("target_addr", imem_addr, 16'h0040);
    step();
    step(); expect_fetch(16'h1040, 16'h0041);

    // HLT on a valid fetch halts next cycle; a branch does not leave HALTED.
    step(); waits = 0; pc_write = 1'b0; halt_detect = 1'b1;
    step(); halt_detect = 1'b0;
    @(negedge clock);
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_req",    {15'd0, imem_req}, 16'd0);
    chk("halt_valid",  {15'd0, fetch_valid}, 16'd0);
    step(); branch_taken = 1'b1; branch_target = 16'h0080;
    step(); branch_taken = 1'b0;
    @(negedge clock);
    chk("halt_sticky", {15'd0, halted}, 16'd1);
    chk("halt_sticky_req", {15'd0, imem_req}, 16'd0);

    // Reset forces idle outputs even from HALTED.
    step(); reset = 1'b0;
    @(negedge clock);
    chk("rst2_req",    {15'd0, imem_req}, 16'd0);
    chk("rst2_halted", {15'd0, halted}, 16'd0);
    chk("rst2_instr",  instruction_register_if, 16'hC0E0);

    // Halt and branch in the same cycle: the redirect wins.
    step(); reset = 1'b1; halt_detect = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100;
    step(); halt_detect = 1'b0; branch_taken = 1'b0; waits = 2; pc_write = 1'b1;
    @(negedge clock);
    chk("hb_halted", {15'd0, halted}, 16'd0);
    chk("hb_addr",   imem_addr, 16'h0100);
    chk("hb_req",    {15'd0, imem_req}, 16'd1);

    // Reset in the middle of a wait: idle outputs, then a fresh fetch from RESET_PC.
    step(); reset = 1'b0;
    @(negedge clock);
    chk("rst3_req",   {15'd0, imem_req}, 16'd0);
    chk("rst3_instr", instruction_register_if, 16'hC0E0);
    chk("rst3_valid", {15'd0, fetch_valid}, 16'd0);
    chk("rst3_busy",  {15'd0, fetch_busy}, 16'd0);
    step(); reset = 1'b1;
    @(negedge clock);
    chk("rst3_addr", imem_addr, 16'h0000);
    chk("rst3_busy_after", {15'd0, fetch_busy}, 16'd1);
    step();
    step(); expect_fetch(16'h1000, 16'h0001);

    // PC wrap: fetch at FFFF gives pc_pre 0000, then 0000 is fetched.
    step(); waits = 0; pc_write = 1'b0; branch_taken = 1'b1; branch_target = 16'hFFFF;
    step(); branch_taken = 1'b0; pc_write = 1'b1; expect_fetch(16'hEFFF, 16'h0000);
    @(negedge clock);
    chk("wrap_addr", imem_addr, 16'hFFFF);
    step(); expect_fetch(16'h1000, 16'h0001);

    // Halt while a fetch waits: drain the request, then HALTED on its ack.
    step(); pc_write = 1'b0; waits = 1; halt_detect = 1'b1;
    @(negedge clock);
    chk("hd_busy",  {15'd0, fetch_busy}, 16'd1);
    chk("hd_valid", {15'd0, fetch_valid}, 16'd0);
    step(); halt_detect = 1'b0;
    @(negedge clock);
    chk("hd_drain_halted", {15'd0, halted}, 16'd0);
    chk("hd_drain_addr",   imem_addr, 16'h0001);
    chk("hd_drain_req",    {15'd0, imem_req}, 16'd1);
    step();
    @(negedge clock);
    chk("hd_halted", {15'd0, halted}, 16'd1);
    chk("hd_req",    {15'd0, imem_req}, 16'd0);

    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
